// File: rtl/cpu_params_pkg.sv
// Core-wide parameters and the RV32M multiply operation encoding.
package cpu_params_pkg;

    localparam int RSZ = 32;
    localparam int HSZ = RSZ / 2;

    typedef enum logic [1:0] {
        IM_MUL    = 2'd0,
        IM_MULH   = 2'd1,
        IM_MULHSU = 2'd2,
        IM_MULHU  = 2'd3
    } IM_OP_TYPE;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared types for the iterative multiply sequencer: FSM states, signedness
// modes and small operand helpers.
package cpu_structs_pkg;

    import cpu_params_pkg::*;

    typedef enum logic [1:0] {
        IMSEQ_IDLE = 2'd0,
        IMSEQ_MULT = 2'd1,
        IMSEQ_FIX  = 2'd2,
        IMSEQ_DONE = 2'd3
    } IMSEQ_STATE_TYPE;

    typedef enum logic [1:0] {
        IM_MODE_UU = 2'd0,
        IM_MODE_SS = 2'd1,
        IM_MODE_SU = 2'd2
    } IM_MODE_TYPE;

    // 0x80000000 maps onto itself, which is the correct magnitude when read unsigned.
    function automatic logic [RSZ-1:0] im_abs(input logic [RSZ-1:0] v);
        return v[RSZ-1] ? (~v + {{(RSZ-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic IM_MODE_TYPE im_mode(input IM_OP_TYPE o);
        IM_MODE_TYPE m;
        case (o)
            IM_MULH:   m = IM_MODE_SS;
            IM_MULHSU: m = IM_MODE_SU;
            default:   m = IM_MODE_UU;
        endcase
        return m;
    endfunction

    function automatic logic [RSZ-1:0] im_select(input logic [2*RSZ-1:0] p,
                                                 input IM_OP_TYPE o);
        return (o == IM_MUL) ? p[RSZ-1:0] : p[2*RSZ-1:RSZ];
    endfunction

endpackage

// File: rtl/vedic_mult16x16.sv
// Combinational 16x16 -> 32 unsigned multiplier built as an Urdhva-Tiryagbhyam
// tree: each level splits operands in half and recombines four sub-products.
module vedic_mult16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] t;
        logic [1:0] hi;
        t  = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        hi = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
        return {hi, t[0], x[0] & y[0]};
    endfunction

    function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] ll, lh, hl, hh;
        logic [4:0] mid;
        ll  = vm2(x[1:0], y[1:0]);
        lh  = vm2(x[1:0], y[3:2]);
        hl  = vm2(x[3:2], y[1:0]);
        hh  = vm2(x[3:2], y[3:2]);
        mid = {1'b0, lh} + {1'b0, hl};
        return {hh, ll} + {1'b0, mid, 2'b00};
    endfunction

    function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] ll, lh, hl, hh;
        logic [8:0] mid;
        ll  = vm4(x[3:0], y[3:0]);
        lh  = vm4(x[3:0], y[7:4]);
        hl  = vm4(x[7:4], y[3:0]);
        hh  = vm4(x[7:4], y[7:4]);
        mid = {1'b0, lh} + {1'b0, hl};
        return {hh, ll} + {3'b000, mid, 4'b0000};
    endfunction

    logic [15:0] ll, lh, hl, hh;
    logic [16:0] mid;

    always_comb begin
        ll  = vm8(a[7:0],  b[7:0]);
        lh  = vm8(a[7:0],  b[15:8]);
        hl  = vm8(a[15:8], b[7:0]);
        hh  = vm8(a[15:8], b[15:8]);
        mid = {1'b0, lh} + {1'b0, hl};
        p   = {hh, ll} + {7'b0000000, mid, 8'h00};
    end

endmodule

// File: rtl/im_seq_ctl.sv
// Iterative RV32M multiply sequencer: one 16x16 multiplier reused over four
// cycles, sign fix-up, one-entry result cache and a valid/ready response.
module im_seq_ctl
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int RSZ      = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic           clk_in,
    input  logic           reset_in,
    input  logic           req_valid,
    output logic           req_ready,
    input  IM_OP_TYPE      op,
    input  logic [RSZ-1:0] rs1_data,
    input  logic [RSZ-1:0] rs2_data,
    input  logic           flush,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [RSZ-1:0] rd_data,
    output logic           busy
);

    localparam int HW = RSZ / 2;

    IMSEQ_STATE_TYPE state, state_nxt;

    logic [1:0]       cnt;
    logic [2*RSZ-1:0] acc;
    IM_OP_TYPE        op_q;
    logic [RSZ-1:0]   m1, m2, rs1_q, rs2_q;
    logic             neg;
    IM_MODE_TYPE      mode_q;

    logic             cache_vld;
    logic [RSZ-1:0]   cache_rs1, cache_rs2;
    IM_MODE_TYPE      cache_mode;
    logic [2*RSZ-1:0] cache_prod;

    logic [RSZ-1:0]   m1_in, m2_in;
    logic             neg_in;
    IM_MODE_TYPE      mode_in;
    logic             accept, hit;

    logic [HW-1:0]    mul_a, mul_b;
    logic [RSZ-1:0]   pp;
    logic [2*RSZ-1:0] pp_shift, prod_fix;

    // Operand preparation for the request currently on the inputs.
    always_comb begin
        m1_in   = rs1_data;
        m2_in   = rs2_data;
        neg_in  = 1'b0;
        mode_in = im_mode(op);
        case (op)
            IM_MULH: begin
                m1_in  = im_abs(rs1_data);
                m2_in  = im_abs(rs2_data);
                neg_in = rs1_data[RSZ-1] ^ rs2_data[RSZ-1];
            end
            IM_MULHSU: begin
                m1_in  = im_abs(rs1_data);
                neg_in = rs1_data[RSZ-1];
            end
            default: ;
        endcase
    end

    assign hit = CACHE_EN && cache_vld && (rs1_data == cache_rs1) &&
                 (rs2_data == cache_rs2) && (mode_in == cache_mode);

    assign accept = req_valid && req_ready;

    // cnt[1] picks the m1 half, cnt[0] the m2 half; cnt 1 and 2 share the 16-bit shift.
    always_comb begin
        mul_a    = cnt[1] ? m1[RSZ-1:HW] : m1[HW-1:0];
        mul_b    = cnt[0] ? m2[RSZ-1:HW] : m2[HW-1:0];
        pp_shift = '0;
        case (cnt)
            2'd0:    pp_shift = {{RSZ{1'b0}}, pp};
            2'd3:    pp_shift = {pp, {RSZ{1'b0}}};
            default: pp_shift = {{HW{1'b0}}, pp, {HW{1'b0}}};
        endcase
        prod_fix = neg ? (~acc + {{(2*RSZ-1){1'b0}}, 1'b1}) : acc;
    end

    vedic_mult16x16 u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IMSEQ_IDLE;
        else          state <= state_nxt;
    end

    // Flush overrides every transition, including a pending response handshake.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IMSEQ_IDLE);
        case (state)
            IMSEQ_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush)
                    state_nxt = hit ? IMSEQ_DONE : IMSEQ_MULT;
            end
            IMSEQ_MULT: if (cnt == 2'd3) state_nxt = IMSEQ_FIX;
            IMSEQ_FIX:  state_nxt = IMSEQ_DONE;
            IMSEQ_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IMSEQ_IDLE;
            end
            default:    state_nxt = IMSEQ_IDLE;
        endcase
        if (flush) state_nxt = IMSEQ_IDLE;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt     <= '0;
            acc     <= '0;
            op_q    <= IM_MUL;
            m1      <= '0;
            m2      <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            neg     <= 1'b0;
            mode_q  <= IM_MODE_UU;
            rd_data <= '0;
        end else begin
            if (accept) begin
                op_q   <= op;
                m1     <= m1_in;
                m2     <= m2_in;
                neg    <= neg_in;
                rs1_q  <= rs1_data;
                rs2_q  <= rs2_data;
                mode_q <= mode_in;
                cnt    <= '0;
                acc    <= '0;
                if (hit) rd_data <= im_select(cache_prod, op);
            end
            if (state == IMSEQ_MULT && !flush) begin
                acc <= acc + pp_shift;
                cnt <= cnt + 2'd1;
            end
            if (state == IMSEQ_FIX && !flush)
                rd_data <= im_select(prod_fix, op_q);
        end
    end

    // The cache key keeps the raw operands plus signedness so MUL and MULHU
    // share an entry while MULH/MULHU on equal operands do not.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cache_vld  <= 1'b0;
            cache_rs1  <= '0;
            cache_rs2  <= '0;
            cache_mode <= IM_MODE_UU;
            cache_prod <= '0;
        end else if (CACHE_EN && state == IMSEQ_FIX && !flush) begin
            cache_vld  <= 1'b1;
            cache_rs1  <= rs1_q;
            cache_rs2  <= rs2_q;
            cache_mode <= mode_q;
            cache_prod <= prod_fix;
        end
    end

endmodule

// File: tb/tb_im_seq_ctl.sv
// Self-checking bench for im_seq_ctl: directed cases, flush, stall/reset and a
// short random run, with expected results queued at issue and popped on response.
module tb_im_seq_ctl;

    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_valid;
    logic        req_ready;
    IM_OP_TYPE   op;
    logic [31:0] rs1_data, rs2_data;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    bit          key_vld = 1'b0;
    logic [31:0] key_a, key_b;
    logic [1:0]  key_m;

    im_seq_ctl #(.RSZ(32), .CACHE_EN(1'b1)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ref_mul(input IM_OP_TYPE o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == IM_MULH || o == IM_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (o == IM_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (o == IM_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [1:0] ref_mode(input IM_OP_TYPE o);
        return (o == IM_MULH) ? 2'd1 : (o == IM_MULHSU) ? 2'd2 : 2'd0;
    endfunction

    // Issues one request, waits for the response and checks latency and data.
    task automatic do_req(input IM_OP_TYPE o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name,
                          input bit release_rsp);
        int n;
        int lat;
        logic [31:0] e;
        exp_q.push_back(exp);
        op = o; rs1_data = a; rs2_data = b; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk_in); #1; n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s req_ready: got %b required 1", name, req_ready);
        end
        @(posedge clk_in); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk_in); #1; lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s rsp_timeout: got rsp_valid=%b required 1", name, rsp_valid);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("[TB] FAIL %s rd_data: got %h required %h", name, rd_data, e);
        end
        if (lat != 1) begin
            key_vld = 1'b1; key_a = a; key_b = b; key_m = ref_mode(o);
        end
        if (release_rsp) begin
            rsp_ready = 1'b1;
            @(posedge clk_in); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        op = IM_MUL; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rd: got %h required 00000000", rd_data);
        end
        reset_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_signs();
        do_req(IM_MUL,    32'd7,        32'd6,        32'h0000002A, 6, "mul_7x6",    1'b1);
        do_req(IM_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6, "mulh_m1",    1'b1);
        do_req(IM_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6, "mulhu_m1",   1'b1);
        do_req(IM_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 6, "mulhsu_min", 1'b1);
        do_req(IM_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 6, "mulh_min",   1'b1);
    endtask

    task automatic test_cache_hit();
        do_req(IM_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 6, "cache_fill", 1'b1);
        do_req(IM_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 1, "cache_hit",  1'b1);
    endtask

    task automatic test_flush();
        // A flush in IDLE must block the accept.
        op = IM_MUL; rs1_data = 32'd9; rs2_data = 32'd9; req_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle_ready: got %b required 0", req_ready);
        end
        @(posedge clk_in); #1;
        req_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle_busy: got %b required 0", busy);
        end
        // Flush in MULT at cnt=2: accept, then cnt0, cnt1, cnt2.
        op = IM_MULH; rs1_data = 32'hDEADBEEF; rs2_data = 32'h12345678; req_valid = 1'b1;
        @(posedge clk_in); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk_in); #1;
        end
        flush = 1'b1;
        @(posedge clk_in); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_mult: got busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
        end
        begin
            bit seen = 1'b0;
            repeat (8) begin
                @(posedge clk_in); #1;
                if (rsp_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("[TB] FAIL flush_no_rsp: got rsp_valid=1 required 0");
            end
        end
        // Prior cache entry survives the flushed operation.
        do_req(IM_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 1, "flush_keep", 1'b1);
        do_req(IM_MULH, 32'hDEADBEEF, 32'h12345678,
               ref_mul(IM_MULH, 32'hDEADBEEF, 32'h12345678), 6, "flush_reissue", 1'b1);
    endtask

    task automatic test_stall_reset();
        logic [31:0] held;
        do_req(IM_MUL, 32'd3, 32'd5, 32'd15, 6, "stall_req", 1'b0);
        held = 32'd15;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rd_data !== held || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: got v=%b rd=%h rdy=%b required 1 %h 0",
                         rsp_valid, rd_data, req_ready, held);
            end
        end
        #2 reset_in = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rd_data !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b rd=%h busy=%b required 0 00000000 0",
                     rsp_valid, rd_data, busy);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        key_vld = 1'b0;
        @(posedge clk_in); #1;
        do_req(IM_MUL, 32'd3, 32'd5, 32'd15, 6, "post_reset_miss", 1'b1);
    endtask

    // Back-to-back random requests; odd iterations reuse operands to provoke hits.
    task automatic test_back_to_back();
        logic [31:0] a, b;
        IM_OP_TYPE   o;
        int          lat;
        a = $urandom; b = $urandom;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                a = $urandom; b = $urandom;
            end
            o = IM_OP_TYPE'($urandom_range(0, 3));
            lat = (key_vld && key_a == a && key_b == b && key_m == ref_mode(o)) ? 1 : 6;
            do_req(o, a, b, ref_mul(o, a, b), lat, "random", 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_cache_hit();
        test_flush();
        test_stall_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
